// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
//   Sequences a PLL out of reset, waits for a stable lock indication, and only
//   then releases the downstream system reset. Retries on lock timeout and
//   gives up (fail) after MAX_RETRIES+1 attempts. Lock loss while running
//   triggers a new sequence.
//
// Ports
//   refclk      in   sole clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   locked      in   PLL lock indicator, asynchronous to refclk
//   restart     in   single-cycle request to re-sequence the PLL
//   pll_rst     out  active-high PLL reset
//   sys_rst_n   out  active-low downstream reset (released only in RUN)
//   ready       out  PLL locked and system released
//   fail        out  lock not achieved within MAX_RETRIES+1 attempts
//   retry_count out  lock timeouts in the current sequence
//   loss_count  out  lock losses seen in RUN since reset, saturating at 255
module pll_lock_sequencer #(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 500000,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_count,
  output logic [7:0] loss_count
);

  localparam int unsigned PW = $clog2(RST_PULSE_CYCLES + 1);
  localparam int unsigned SW = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
  localparam int unsigned TW = $clog2(LOCK_TIMEOUT_CYCLES);

  localparam logic [PW-1:0] PULSE_LAST  = PW'(RST_PULSE_CYCLES);
  localparam logic [PW-1:0] PULSE_FIRST = PW'(1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST    = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRIES);

  typedef enum logic [1:0] {
    ST_RESET_PLL,
    ST_WAIT_LOCK,
    ST_RUN,
    ST_FAIL
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pulse_q, pulse_d;
  logic [SW-1:0] stable_q, stable_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [3:0]    retry_q, retry_d;
  logic [7:0]    loss_q, loss_d;
  logic          sync1_q, sync1_d;
  logic          locked_s_q, locked_s_d;
  logic          pll_rst_q, pll_rst_d;
  logic          sys_rst_n_q, sys_rst_n_d;
  logic          ready_q, ready_d;
  logic          fail_q, fail_d;

  always_comb begin
    state_d  = state_q;
    pulse_d  = pulse_q;
    stable_d = stable_q;
    tmo_d    = tmo_q;
    retry_d  = retry_q;
    loss_d   = loss_q;

    // The lock indicator of a PLL held in reset is meaningless, so the
    // synchronizer is flushed during the pulse; stability counting then only
    // ever sees lock sampled after the PLL was released.
    if (state_q == ST_RESET_PLL) begin
      sync1_d    = 1'b0;
      locked_s_d = 1'b0;
    end else begin
      sync1_d    = locked;
      locked_s_d = sync1_q;
    end

    // pulse_q counts pulse cycles including the current one; 0 after rst_n
    // means "not started", so the first edge after release is pulse cycle 1,
    // matching the cycle-1 load on every other entry into RESET_PLL.
    if (restart) begin
      state_d = ST_RESET_PLL;
      pulse_d = PULSE_FIRST;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_RESET_PLL: begin
          if (pulse_q == PULSE_LAST) begin
            state_d  = ST_WAIT_LOCK;
            stable_d = '0;
            tmo_d    = '0;
          end else begin
            pulse_d = pulse_q + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          // Stability completing on the last timeout cycle still wins.
          if (locked_s_q && (stable_q == STABLE_LAST)) begin
            state_d = ST_RUN;
            retry_d = '0;
          end else if (tmo_q == TMO_LAST) begin
            if (retry_q == RETRY_MAX) begin
              state_d = ST_FAIL;
            end else begin
              state_d = ST_RESET_PLL;
              pulse_d = PULSE_FIRST;
              retry_d = retry_q + 1'b1;
            end
          end else begin
            tmo_d    = tmo_q + 1'b1;
            stable_d = locked_s_q ? stable_q + 1'b1 : '0;
          end
        end
        ST_RUN: begin
          if (!locked_s_q) begin
            state_d = ST_RESET_PLL;
            pulse_d = PULSE_FIRST;
            if (loss_q != '1) begin
              loss_d = loss_q + 1'b1;
            end
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_RESET_PLL;
          pulse_d = PULSE_FIRST;
        end
      endcase
    end

    // Outputs are decoded from the next state so they register together
    // with the state itself.
    pll_rst_d   = (state_d == ST_RESET_PLL);
    sys_rst_n_d = (state_d == ST_RUN);
    ready_d     = (state_d == ST_RUN);
    fail_d      = (state_d == ST_FAIL);
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RESET_PLL;
      pulse_q     <= '0;
      stable_q    <= '0;
      tmo_q       <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      sync1_q     <= 1'b0;
      locked_s_q  <= 1'b0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pulse_q     <= pulse_d;
      stable_q    <= stable_d;
      tmo_q       <= tmo_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      sync1_q     <= sync1_d;
      locked_s_q  <= locked_s_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
    end
  end

  assign pll_rst     = pll_rst_q;
  assign sys_rst_n   = sys_rst_n_q;
  assign ready       = ready_q;
  assign fail        = fail_q;
  assign retry_count = retry_q;
  assign loss_count  = loss_q;

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 SHALL have parameter RST_PULSE_CYCLES, default 16: PLL reset pulse length in refclk cycles (>=1).
REQ-002 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before release (>=1).
REQ-003 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 500000: maximum cycles in WAIT_LOCK per attempt (> LOCK_STABLE_CYCLES).
REQ-004 SHALL have parameter MAX_RETRIES, default 3: timeouts tolerated before FAIL (0..15).
REQ-005 SHALL have port refclk, input, 1: sole clock; one clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port locked, input, 1: PLL lock indicator, asynchronous to refclk.
REQ-008 SHALL have port restart, input, 1: synchronous single-cycle request to re-sequence the PLL.
REQ-009 SHALL have port pll_rst, output, 1: active-high PLL reset drive.
REQ-010 SHALL have port sys_rst_n, output, 1: active-low downstream system reset.
REQ-011 SHALL have port ready, output, 1: PLL locked and system released.
REQ-012 SHALL have port fail, output, 1: lock not achieved within MAX_RETRIES+1 attempts.
REQ-013 SHALL have port retry_count, output, 4: timeouts in the current sequence.
REQ-014 SHALL have port loss_count, output, 8: lock losses observed in RUN since reset, saturating at 255.

Function
REQ-015 SHALL pass locked through a two-flop synchronizer (locked_s); no other logic uses raw locked.
REQ-016 SHALL implement states RESET_PLL, WAIT_LOCK, RUN, FAIL; all outputs registered, decoded from state.
REQ-017 SHALL drive pll_rst=1 iff state==RESET_PLL; sys_rst_n=1 and ready=1 iff state==RUN; fail=1 iff state==FAIL.
REQ-018 RESET_PLL SHALL last exactly RST_PULSE_CYCLES cycles, then enter WAIT_LOCK with stable and timeout counters cleared.
REQ-019 WAIT_LOCK: stable counter increments on locked_s=1 and clears on locked_s=0; timeout counter increments every cycle.
REQ-020 WAIT_LOCK SHALL enter RUN in the cycle after locked_s has been 1 for LOCK_STABLE_CYCLES consecutive cycles; retry_count clears on entry.
REQ-021 WAIT_LOCK timeout (LOCK_TIMEOUT_CYCLES cycles elapsed without REQ-020) SHALL go to FAIL if retry_count==MAX_RETRIES, else increment retry_count and go to RESET_PLL.
REQ-022 Stability completion and timeout in the same cycle: stability wins (RUN).
REQ-023 RUN: locked_s=0 for one cycle SHALL go to RESET_PLL next cycle, increment loss_count (saturating), and deassert ready/sys_rst_n.
REQ-024 FAIL SHALL hold pll_rst=0, sys_rst_n=0, ready=0 and exit only on restart or rst_n.
REQ-025 restart=1 in any state SHALL go to RESET_PLL next cycle with retry_count cleared; loss_count unchanged; restart has priority over all other transitions.
REQ-026 restart held high SHALL hold the block in RESET_PLL with its pulse counter reloaded each cycle.
REQ-027 Counters SHALL be sized by $clog2 of their parameter; no wrap-around permitted in any state.

Reset
REQ-028 rst_n=0 SHALL immediately force state RESET_PLL with counter 0, synchronizer flops 0, pll_rst=1, sys_rst_n=0, ready=0, fail=0, retry_count=0, loss_count=0.
REQ-029 On rst_n release the block SHALL begin the RST_PULSE_CYCLES pulse at the first refclk edge; rst_n assertion mid-sequence aborts it identically.

Verification (RST_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=64, MAX_RETRIES=2)
REQ-030 Bench SHALL cover: release rst_n, locked=1 constant -> pll_rst high exactly 4 cycles; ready=1 and sys_rst_n=1 at 4+2+8+1 cycles, +/-0 tolerance.
REQ-031 Bench SHALL cover: locked toggles 0 every 5th cycle in WAIT_LOCK -> no RUN; after 64 cycles retry_count=1 and pll_rst pulses 4 cycles again.
REQ-032 Bench SHALL cover: locked=0 forever -> three 4-cycle pll_rst pulses, then fail=1, retry_count=2, pll_rst=0; restart pulse -> fail=0, retry_count=0, pll_rst=1 next cycle.
REQ-033 Bench SHALL cover: in RUN, drop locked for 1 cycle -> ready=0 three cycles later, loss_count=1, re-lock -> RUN again; 300 such losses -> loss_count=255.
REQ-034 Bench SHALL cover: locked stable at cycle 63 of WAIT_LOCK (count completes with timeout) -> RUN, retry_count=0.
REQ-035 Bench SHALL cover: rst_n asserted mid-WAIT_LOCK between clock edges -> all outputs at reset values before next refclk edge.
